// File: rtl/state_log_pkg.sv
// Shared definitions for the state-change log reader: FSM encoding and default sizing.
// `LOG_READER_PARITY_EN appends an even-parity bit to every frame.
package state_log_pkg;

    localparam int DEFAULT_BITS  = 16;
    localparam int DEFAULT_CNT_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_SHIFT = 3'd2,
        ST_CLEAR = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic int frame_len(input int bits);
`ifdef LOG_READER_PARITY_EN
        return bits + 1;
`else
        return bits;
`endif
    endfunction

endpackage

// File: rtl/log_shift_out.sv
// Snapshot shift register and bit counter for the log reader; flags the last frame bit.
// With `LOG_READER_PARITY_EN the snapshot parity is shifted in behind the data bits.
module log_shift_out
    import state_log_pkg::*;
#(
    parameter int BITS  = DEFAULT_BITS,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic            iClk,
    input  logic            iRst_n,
    input  logic            load_i,
    input  logic            shift_i,
    input  logic [BITS-1:0] data_i,
    output logic            msb_o,
    output logic            last_o
);

    localparam int FRAME_LEN = frame_len(BITS);

    logic [BITS-1:0]  shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fill;

`ifdef LOG_READER_PARITY_EN
    logic parity_q;

    // Parity enters at the LSB, so it reaches the MSB exactly after the BITS data shifts.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n)     parity_q <= 1'b0;
        else if (load_i) parity_q <= ^data_i;
    end

    assign fill = parity_q;
`else
    assign fill = 1'b0;
`endif

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (load_i) begin
            shreg_d = data_i;
            cnt_d   = '0;
        end else if (shift_i) begin
            shreg_d = {shreg_q[BITS-2:0], fill};
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign msb_o  = shreg_q[BITS-1];
    assign last_o = (cnt_q == CNT_W'(FRAME_LEN - 1));

endmodule

// File: rtl/state_change_log_reader.sv
// Readout end of the state-change logger: snapshot, MSB-first serial frame, optional clear.
// `LOG_READER_PARITY_EN adds an even-parity bit after the data bits.
module state_change_log_reader
    import state_log_pkg::*;
#(
    parameter int BITS  = DEFAULT_BITS,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic            iClk,
    input  logic            iRst_n,
    input  logic [BITS-1:0] iChange,
    input  logic            iReadReq,
    input  logic            iShiftEn,
    input  logic            iAbort,
    input  logic            iAutoClear,
    output logic            oSerData,
    output logic            oFrameValid,
    output logic            oBusy,
    output logic            oDone,
    output logic            oClear_n,
    output logic            oPending
);

    state_t state_q, state_d;
    logic   load, shift, msb, last_bit;
    logic   pending_q;

    log_shift_out #(.BITS(BITS), .CNT_W(CNT_W)) u_shift (
        .iClk    (iClk),
        .iRst_n  (iRst_n),
        .load_i  (load),
        .shift_i (shift),
        .data_i  (iChange),
        .msb_o   (msb),
        .last_o  (last_bit)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            ST_IDLE:  if (iReadReq) state_d = ST_LATCH;
            ST_LATCH: begin
                load    = 1'b1;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: if (iShiftEn) begin
                shift = 1'b1;
                if (last_bit) state_d = iAutoClear ? ST_CLEAR : ST_DONE;
            end
            ST_CLEAR: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        // Abort wins over everything, including the final shift of a frame.
        if (iAbort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            load    = 1'b0;
            shift   = 1'b0;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q   <= ST_IDLE;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= |iChange;
        end
    end

    assign oFrameValid = (state_q == ST_SHIFT);
    assign oSerData    = oFrameValid & msb;
    assign oBusy       = (state_q != ST_IDLE);
    assign oDone       = (state_q == ST_DONE);
    assign oClear_n    = (state_q != ST_CLEAR);
    assign oPending    = pending_q;

endmodule

// File: tb/tb_state_change_log_reader.sv
// Bench for state_change_log_reader (BITS=8); serial bits checked against a scoreboard queue.
// Also builds with `LOG_READER_PARITY_EN to cover the parity frame.
module tb_state_change_log_reader;

`ifdef LOG_READER_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] iChange = '0;
    logic       iReadReq = 1'b0, iShiftEn = 1'b0, iAbort = 1'b0, iAutoClear = 1'b0;
    logic       oSerData, oFrameValid, oBusy, oDone, oClear_n, oPending;

    int n_checks = 0, n_fail = 0;
    int done_cnt = 0, clr_cnt = 0, bits_seen = 0;
    logic done_prev_clr = 1'b0, prev_clr_low = 1'b0;
    logic [0:0] exp_q[$];

    typedef struct {
        logic [7:0] chg;
        logic       ac;
        logic [7:0] chg_mid;
        logic       req_mid;
        int         exp_cycles;
        int         exp_clr;
    } vec_t;
    vec_t vecs[7];

    state_change_log_reader #(.BITS(8), .CNT_W(4)) dut (
        .iClk        (clk),
        .iRst_n      (rst_n),
        .iChange     (iChange),
        .iReadReq    (iReadReq),
        .iShiftEn    (iShiftEn),
        .iAbort      (iAbort),
        .iAutoClear  (iAutoClear),
        .oSerData    (oSerData),
        .oFrameValid (oFrameValid),
        .oBusy       (oBusy),
        .oDone       (oDone),
        .oClear_n    (oClear_n),
        .oPending    (oPending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [7:0] chg);
        for (int i = 7; i >= 0; i--) exp_q.push_back(chg[i]);
`ifdef LOG_READER_PARITY_EN
        exp_q.push_back(^chg);
`endif
    endtask

    task automatic clear_counts();
        done_cnt  = 0;
        clr_cnt   = 0;
        bits_seen = 0;
        done_prev_clr = 1'b0;
    endtask

    // Serial monitor: every consumed bit is popped from the scoreboard and compared.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prev_clr_low = 1'b0;
        end else begin
            if (oFrameValid && iShiftEn) begin
                bits_seen++;
                if (exp_q.size() == 0) check("unexpected_bit", 1, 0);
                else check("ser_bit", oSerData, exp_q.pop_front());
            end
            if (oDone) begin
                done_cnt++;
                done_prev_clr = prev_clr_low;
            end
            if (!oClear_n) clr_cnt++;
            prev_clr_low = !oClear_n;
        end
    end

    task automatic run_frame(input vec_t v);
        int cycles;
        exp_q.delete();
        push_frame(v.chg);
        clear_counts();
        iChange    = v.chg;
        iAutoClear = v.ac;
        iShiftEn   = 1'b1;
        iReadReq   = 1'b1;
        tick();
        iReadReq = 1'b0;
        check("latch_busy", oBusy, 1);
        check("latch_not_valid", oFrameValid, 0);
        tick();
        cycles = 2;
        check("shift_valid", oFrameValid, 1);
        iChange = v.chg_mid;
        while (oBusy && cycles < 200) begin
            iReadReq = (cycles == 4) ? v.req_mid : 1'b0;
            tick();
            cycles++;
        end
        iShiftEn = 1'b0;
        iReadReq = 1'b0;
        if (cycles >= 200) check("frame_timeout", 1, 0);
        check("frame_cycles", cycles, v.exp_cycles);
        check("bits_seen", bits_seen, FL);
        check("done_count", done_cnt, 1);
        check("clear_count", clr_cnt, v.exp_clr);
        check("clear_before_done", done_prev_clr, v.exp_clr);
        check("queue_empty", exp_q.size(), 0);
        check("idle_clear_n", oClear_n, 1);
    endtask

    initial begin
        vecs[0] = '{chg: 8'hA5, ac: 1'b0, chg_mid: 8'hA5, req_mid: 1'b0, exp_cycles: FL + 3, exp_clr: 0};
        vecs[1] = '{chg: 8'hA5, ac: 1'b1, chg_mid: 8'hA5, req_mid: 1'b0, exp_cycles: FL + 4, exp_clr: 1};
        vecs[2] = '{chg: 8'h01, ac: 1'b0, chg_mid: 8'hFF, req_mid: 1'b0, exp_cycles: FL + 3, exp_clr: 0};
        vecs[3] = '{chg: 8'h3C, ac: 1'b0, chg_mid: 8'h3C, req_mid: 1'b1, exp_cycles: FL + 3, exp_clr: 0};
        vecs[4] = '{chg: 8'h80, ac: 1'b1, chg_mid: 8'h00, req_mid: 1'b0, exp_cycles: FL + 4, exp_clr: 1};
        vecs[5] = '{chg: 8'h07, ac: 1'b0, chg_mid: 8'h07, req_mid: 1'b0, exp_cycles: FL + 3, exp_clr: 0};
        vecs[6] = '{chg: 8'(32'($urandom_range(1, 255))), ac: 1'b1, chg_mid: 8'h5A, req_mid: 1'b1,
                    exp_cycles: FL + 4, exp_clr: 1};

        #2;
        check("rst_ser", oSerData, 0);
        check("rst_valid", oFrameValid, 0);
        check("rst_busy", oBusy, 0);
        check("rst_done", oDone, 0);
        check("rst_clear_n", oClear_n, 1);
        check("rst_pending", oPending, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Shift ticks and an abort in IDLE do nothing.
        iShiftEn = 1'b1;
        iAbort   = 1'b1;
        tick();
        tick();
        check("idle_shift_busy", oBusy, 0);
        check("idle_shift_valid", oFrameValid, 0);
        check("idle_pending_zero", oPending, 0);
        iShiftEn = 1'b0;
        iAbort   = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i]);
            if (i == 2) check("pending_after_change", oPending, 1);
            if (i == 4) check("pending_cleared_vec", oPending, 0);
            tick();
        end

        // Abort after three bits, with auto-clear requested.
        exp_q.delete();
        push_frame(8'hC3);
        while (exp_q.size() > 3) void'(exp_q.pop_back());
        clear_counts();
        iChange = 8'hC3;
        iAutoClear = 1'b1;
        iReadReq = 1'b1;
        tick();
        iReadReq = 1'b0;
        tick();
        iShiftEn = 1'b1;
        tick();
        tick();
        tick();
        iShiftEn = 1'b0;
        iAbort = 1'b1;
        tick();
        iAbort = 1'b0;
        check("abort_busy", oBusy, 0);
        check("abort_valid", oFrameValid, 0);
        tick();
        tick();
        check("abort_bits", bits_seen, 3);
        check("abort_no_done", done_cnt, 0);
        check("abort_no_clear", clr_cnt, 0);
        run_frame('{chg: 8'hC3, ac: 1'b0, chg_mid: 8'hC3, req_mid: 1'b0, exp_cycles: FL + 3, exp_clr: 0});
        tick();

        // Abort on the same cycle as the final shift.
        exp_q.delete();
        push_frame(8'h96);
        clear_counts();
        iChange = 8'h96;
        iAutoClear = 1'b1;
        iReadReq = 1'b1;
        tick();
        iReadReq = 1'b0;
        tick();
        iShiftEn = 1'b1;
        for (int i = 0; i < FL - 1; i++) tick();
        iAbort = 1'b1;
        tick();
        iAbort = 1'b0;
        iShiftEn = 1'b0;
        check("last_abort_busy", oBusy, 0);
        tick();
        tick();
        check("last_abort_bits", bits_seen, FL);
        check("last_abort_no_done", done_cnt, 0);
        check("last_abort_no_clear", clr_cnt, 0);

        // Asynchronous reset mid-frame.
        exp_q.delete();
        push_frame(8'hF0);
        iChange = 8'hF0;
        iReadReq = 1'b1;
        tick();
        iReadReq = 1'b0;
        tick();
        iShiftEn = 1'b1;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ser", oSerData, 0);
        check("arst_valid", oFrameValid, 0);
        check("arst_busy", oBusy, 0);
        check("arst_done", oDone, 0);
        check("arst_clear_n", oClear_n, 1);
        check("arst_pending", oPending, 0);
        iShiftEn = 1'b0;
        tick();
        exp_q.delete();
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_pending", oPending, 1);
        run_frame('{chg: 8'h5E, ac: 1'b1, chg_mid: 8'h5E, req_mid: 1'b0, exp_cycles: FL + 4, exp_clr: 1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
